// File: rtl/data_mem_display_reader_pkg.sv
// Shared types and constants for the data-memory display reader.
package data_mem_display_reader_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 4;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned DIG_W = 2;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    LATCH  = 2'd1,
    SHOW   = 2'd2
  } state_e;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [AN_W-1:0]  AN_OFF    = 4'hF;

endpackage

// File: rtl/data_mem_display_reader_hex7seg.sv
// hex7seg: pure combinational nibble to active-low seven-segment decoder.
module data_mem_display_reader_hex7seg
  import data_mem_display_reader_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  // Hex glyph lookup
  always_comb begin
    seg_c = SEG_BLANK;
    case (nibble)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/data_mem_display_reader.sv
// Display-port reader: steps a word index, captures the memory word and
// scans one 16-bit half onto a 4-digit multiplexed seven-segment display.
module data_mem_display_reader
  import data_mem_display_reader_pkg::*;
#(
  parameter int unsigned B           = 32,
  parameter int unsigned W           = 12,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step_next,
  input  logic             step_prev,
  input  logic             half_sel,
  output logic [W-1:0]     display_number,
  input  logic [B-1:0]     display_data,
  output logic             word_valid,
  output logic [AN_W-1:0]  an,
  output logic [SEG_W-1:0] seg,
  output logic             dp
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(3);

  state_e state_q, state_d;

  logic [B-1:0]       word_q;
  logic               pend_next_q, pend_prev_q;
  logic               pend_next_d, pend_prev_d;
  logic [CNT_W-1:0]   refresh_cnt_q;
  logic [DIG_W-1:0]   digit_q;

  logic               req_next_c, req_prev_c;
  logic               want_next_c, want_prev_c;
  logic               apply_next_c, apply_prev_c, latch_en_c;
  logic               dwell_end_c, frame_end_c, scan_tick_c;
  logic [15:0]        half_c;
  logic [NIB_W-1:0]   nibble_c;
  logic [SEG_W-1:0]   glyph_c;

  // Same-cycle opposite pulses cancel; pending and live requests merge to one step
  assign req_next_c  = step_next & ~step_prev;
  assign req_prev_c  = step_prev & ~step_next;
  assign want_next_c = (pend_next_q | req_next_c) & ~(pend_prev_q | req_prev_c);
  assign want_prev_c = (pend_prev_q | req_prev_c) & ~(pend_next_q | req_next_c);

  assign dwell_end_c = (refresh_cnt_q == CNT_LAST);
  assign frame_end_c = dwell_end_c && (digit_q == DIG_LAST);
  assign scan_tick_c = (refresh_cnt_q == '0);

  assign half_c   = half_sel ? word_q[31:16] : word_q[15:0];
  assign nibble_c = half_c[{digit_q, 2'b00} +: NIB_W];

  data_mem_display_reader_hex7seg u_hex7seg (
    .nibble (nibble_c),
    .seg_c  (glyph_c)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SETTLE;
    else          state_q <= state_d;
  end

  // FSM next state: recapture after every index change or frame end
  always_comb begin
    state_d = state_q;
    case (state_q)
      SETTLE:  state_d = LATCH;
      LATCH:   state_d = SHOW;
      SHOW:    if (want_next_c || want_prev_c || frame_end_c) state_d = SETTLE;
      default: state_d = SETTLE;
    endcase
  end

  // FSM outputs: step application, capture strobe and pending bookkeeping
  always_comb begin
    apply_next_c = 1'b0;
    apply_prev_c = 1'b0;
    latch_en_c   = 1'b0;
    pend_next_d  = pend_next_q;
    pend_prev_d  = pend_prev_q;
    case (state_q)
      SHOW: begin
        apply_next_c = want_next_c;
        apply_prev_c = want_prev_c;
        pend_next_d  = 1'b0;
        pend_prev_d  = 1'b0;
      end
      SETTLE, LATCH: begin
        latch_en_c = (state_q == LATCH);
        if (req_next_c) begin
          if (pend_prev_q) pend_prev_d = 1'b0;
          else             pend_next_d = 1'b1;
        end
        if (req_prev_c) begin
          if (pend_next_q) pend_next_d = 1'b0;
          else             pend_prev_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Index, captured word and validity flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      display_number <= '0;
      word_q         <= '0;
      word_valid     <= 1'b0;
      pend_next_q    <= 1'b0;
      pend_prev_q    <= 1'b0;
    end else begin
      pend_next_q <= pend_next_d;
      pend_prev_q <= pend_prev_d;
      if (apply_next_c) begin
        display_number <= display_number + W'(1);
        word_valid     <= 1'b0;
      end else if (apply_prev_c) begin
        display_number <= display_number - W'(1);
        word_valid     <= 1'b0;
      end else if (latch_en_c) begin
        word_valid <= 1'b1;
      end
      if (latch_en_c) word_q <= display_data;
    end
  end

  // Digit dwell counter and digit index, free-running through recapture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt_q <= '0;
      digit_q       <= '0;
    end else if (dwell_end_c) begin
      refresh_cnt_q <= '0;
      digit_q       <= digit_q + DIG_W'(1);
    end else begin
      refresh_cnt_q <= refresh_cnt_q + CNT_W'(1);
    end
  end

  // Anode, segment and dp registered together once per digit dwell
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (scan_tick_c) begin
      an  <= ~(AN_W'(1) << digit_q);
      seg <= glyph_c;
      dp  <= ~(half_sel & (digit_q == DIG_LAST));
    end
  end

endmodule

// File: tb/tb_data_mem_display_reader.sv
// Scoreboard bench for data_mem_display_reader with a behavioural memory.
module tb_data_mem_display_reader;

  localparam int unsigned B   = 32;
  localparam int unsigned W   = 12;
  localparam int unsigned DIV = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  logic         clk;
  logic         reset_n;
  logic         step_next, step_prev, half_sel;
  logic [W-1:0] display_number;
  logic [B-1:0] display_data;
  logic         word_valid;
  logic [3:0]   an;
  logic [6:0]   seg;
  logic         dp;

  logic [31:0]  mem [4096];
  assign display_data = mem[display_number];

  int           vectors = 0;
  int           fails   = 0;
  int           model_idx = 0;
  logic [W-1:0] exp_idx [$];
  disp_t        exp_disp [$];
  bit           idx_busy = 1'b0;

  data_mem_display_reader #(.B(B), .W(W), .REFRESH_DIV(DIV)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .step_next      (step_next),
    .step_prev      (step_prev),
    .half_sel       (half_sel),
    .display_number (display_number),
    .display_data   (display_data),
    .word_valid     (word_valid),
    .an             (an),
    .seg            (seg),
    .dp             (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dn"},  32'(display_number), 32'h0);
    check({tag, "_wv"},  32'(word_valid),     32'h0);
    check({tag, "_an"},  32'(an),             32'hF);
    check({tag, "_seg"}, 32'(seg),            32'h7F);
    check({tag, "_dp"},  32'(dp),             32'h1);
  endtask

  // Wait for the first cycle of a digit-3 dwell
  task automatic sync_frame();
    logic [3:0] p;
    bit found;
    p = an;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b0111 && p != 4'b0111) found = 1'b1;
      p = an;
    end
    if (!found) begin
      vectors++; fails++;
      $display("FAIL sync_timeout: got an=%b required an=0111 within 64 cycles", an);
    end
  endtask

  task automatic push_frame();
    logic [31:0] w;
    logic [15:0] h;
    disp_t e;
    @(negedge clk);
    w = mem[model_idx];
    h = half_sel ? w[31:16] : w[15:0];
    for (int d = 0; d < 4; d++) begin
      e.an  = 4'(~(4'b0001 << d));
      e.seg = glyph(h[d*4 +: 4]);
      e.dp  = (d == 3 && half_sel) ? 1'b0 : 1'b1;
      exp_disp.push_back(e);
    end
  endtask

  task automatic wait_disp();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 48 && !done; i++) begin
      @(negedge clk);
      if (exp_disp.size() == 0) done = 1'b1;
    end
    if (!done) begin
      vectors++; fails++;
      $display("FAIL disp_timeout: got %0d digits pending required 0", exp_disp.size());
      exp_disp.delete();
    end
  endtask

  task automatic check_frame();
    sync_frame();
    sync_frame();
    push_frame();
    wait_disp();
  endtask

  task automatic expect_step(input int dir);
    model_idx = (model_idx + 4096 + dir) % 4096;
    exp_idx.push_back(W'(model_idx));
  endtask

  task automatic pulse(input logic n, input logic p);
    step_next = n;
    step_prev = p;
    @(negedge clk);
    step_next = 1'b0;
    step_prev = 1'b0;
  endtask

  task automatic wait_idx(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (exp_idx.size() == 0 && !idx_busy) done = 1'b1;
    end
    if (!done) begin
      vectors++; fails++;
      $display("FAIL %s_timeout: got %0d index changes pending required 0", name, exp_idx.size());
      exp_idx.delete();
    end
    repeat (6) @(negedge clk);
    check({name, "_idx"}, 32'(display_number), 32'(model_idx));
    check({name, "_wv"},  32'(word_valid),     32'h1);
  endtask

  // Index monitor: every index change must be expected and drop word_valid for two cycles
  initial begin
    logic [W-1:0] prev_dn;
    logic [W-1:0] e;
    prev_dn = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_dn = display_number;
      end else if (display_number != prev_dn) begin
        prev_dn  = display_number;
        idx_busy = 1'b1;
        vectors++;
        if (exp_idx.size() == 0) begin
          fails++;
          $display("FAIL idx_unexpected: got display_number=%0d required no change", display_number);
        end else begin
          e = exp_idx.pop_front();
          if (display_number !== e) begin
            fails++;
            $display("FAIL idx_value: got %0d expected %0d", display_number, e);
          end
        end
        check("wv_low_c1", 32'(word_valid), 32'h0);
        @(negedge clk);
        check("wv_low_c2", 32'(word_valid), 32'h0);
        @(negedge clk);
        check("wv_high_c3", 32'(word_valid), 32'h1);
        idx_busy = 1'b0;
      end
    end
  end

  // Validity monitor: word_valid may only fall together with an index change
  initial begin
    logic         prev_wv;
    logic [W-1:0] prev_dn;
    prev_wv = 1'b0;
    prev_dn = '0;
    forever begin
      @(negedge clk);
      if (reset_n && prev_wv && !word_valid) begin
        vectors++;
        if (display_number == prev_dn) begin
          fails++;
          $display("FAIL wv_drop: got word_valid=0 at index %0d required 1 (no index change)", display_number);
        end
      end
      prev_wv = word_valid;
      prev_dn = display_number;
    end
  end

  // Display monitor: each digit update compared against the next expected digit
  initial begin
    logic [3:0] prev_an;
    int gap;
    disp_t e;
    prev_an = 4'hF;
    gap = 0;
    forever begin
      @(negedge clk);
      gap++;
      if (an != prev_an) begin
        if (reset_n && exp_disp.size() > 0) begin
          e = exp_disp.pop_front();
          vectors++;
          if (an !== e.an || seg !== e.seg || dp !== e.dp || gap != DIV) begin
            fails++;
            $display("FAIL disp_digit: got an=%b seg=%b dp=%b gap=%0d expected an=%b seg=%b dp=%b gap=%0d",
                     an, seg, dp, gap, e.an, e.seg, e.dp, DIV);
          end
        end
        gap = 0;
        prev_an = an;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish before 500000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i) * 32'h0001_0001;
    mem[0]    = 32'h1234_ABCD;
    mem[1]    = 32'hCAFE_5678;
    mem[4]    = 32'h9876_5E0F;
    mem[4095] = 32'h00C0_FFEE;

    reset_n = 1'b0; step_next = 1'b0; step_prev = 1'b0; half_sel = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("boot_wv", 32'(word_valid), 32'h1);
    check("boot_dn", 32'(display_number), 32'h0);

    // Word 0, low half then high half
    check_frame();
    half_sel = 1'b1;
    check_frame();
    half_sel = 1'b0;

    // Single step forward and display of the new word
    sync_frame(); expect_step(1); pulse(1'b1, 1'b0); wait_idx("next_0to1");
    check_frame();

    // Overwrite the shown word: picked up by periodic recapture
    @(negedge clk); mem[1] = 32'h0000_FFFF;
    check_frame();
    half_sel = 1'b1;
    check_frame();
    half_sel = 1'b0;

    // Wrap-around in both directions
    sync_frame(); expect_step(-1); pulse(1'b0, 1'b1); wait_idx("prev_1to0");
    sync_frame(); expect_step(-1); pulse(1'b0, 1'b1); wait_idx("prev_wrap");
    check_frame();
    sync_frame(); expect_step(1); pulse(1'b1, 1'b0); wait_idx("next_wrap");

    // Simultaneous pulses cancel
    sync_frame(); pulse(1'b1, 1'b1); wait_idx("cancel");

    // Pulse landing in SETTLE is deferred to the first SHOW cycle
    sync_frame(); expect_step(1); expect_step(1);
    pulse(1'b1, 1'b0); pulse(1'b1, 1'b0); wait_idx("pend_settle");

    // Two pulses during SETTLE/LATCH still give a single deferred step
    sync_frame(); expect_step(1); expect_step(1);
    pulse(1'b1, 1'b0); pulse(1'b1, 1'b0); pulse(1'b1, 1'b0); wait_idx("pend_drop");
    check_frame();

    // Opposite pulse while pending cancels the pending step
    sync_frame(); expect_step(1);
    pulse(1'b1, 1'b0); pulse(1'b1, 1'b0); pulse(1'b0, 1'b1); wait_idx("pend_cancel");

    // Asynchronous reset mid-operation
    @(negedge clk); #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_idx = 0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst2_wv", 32'(word_valid), 32'h1);
    check_frame();

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
